instr_stream_loader: RTL and testbench

- Synthesizable byte-stream instruction loader between the external 8-bit `instr_i`-style pin and the CPU instruction memory.
- Receives a framed byte stream and assembles WORD_BYTES-byte words, with configurable byte order.
- Writes each word to sequential memory addresses.
- Reports completion, word count, overflow and partial-word errors.
- Replaces bench-side memory preloading with an in-hardware load path usable from one 8-bit port.

---
 rtl/instr_stream_loader.sv | 206 ++++++++++++++++++++
 tb/tb_instr_stream_loader.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_stream_loader.sv
// instr_stream_loader
// Turns a framed 8-bit byte stream into word writes to an instruction memory.
// Control bytes: 0xFE starts (or restarts) a frame, 0xFF ends it, and 0xFD
// escapes the following byte so it is always taken as data. Completed words
// are written to consecutive addresses starting at 0. An END that leaves a
// partial word writes it zero-padded and raises the sticky partial flag.
// Words completed while the memory is full are dropped and raise the sticky
// overflow flag.
module instr_stream_loader #(
    parameter int WORD_BYTES = 4,
    parameter int DEPTH      = 64,
    parameter int ADDR_W     = 6,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    reset,
    input  logic                    byte_valid_i,
    input  logic [7:0]              byte_i,
    output logic                    mem_we_o,
    output logic [ADDR_W-1:0]       mem_addr_o,
    output logic [8*WORD_BYTES-1:0] mem_wdata_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [ADDR_W:0]         word_count_o,
    output logic                    overflow_o,
    output logic                    partial_o
);

    localparam int IDX_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int WORD_W = 8 * WORD_BYTES;

    localparam logic [7:0] BYTE_START = 8'hFE;
    localparam logic [7:0] BYTE_END   = 8'hFF;
    localparam logic [7:0] BYTE_ESC   = 8'hFD;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_ESC  = 2'd2;

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(WORD_BYTES - 1);
    localparam logic [ADDR_W:0]  FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    logic [1:0]        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [7:0]        lane_q  [WORD_BYTES];
    logic [7:0]        lane_d  [WORD_BYTES];
    logic [7:0]        lane_wr [WORD_BYTES];
    logic [ADDR_W:0]   count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              partial_q, partial_d;
    logic              we_q, we_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic [WORD_W-1:0] word_asm;

    logic restart_en;
    logic store_en;
    logic end_en;
    logic emit_en;
    logic mem_full;

    // Classify the incoming byte against the current framing state.
    always_comb begin
        state_d    = state_q;
        restart_en = 1'b0;
        store_en   = 1'b0;
        end_en     = 1'b0;
        if (byte_valid_i) begin
            case (state_q)
                ST_IDLE: begin
                    if (byte_i == BYTE_START) begin
                        restart_en = 1'b1;
                        state_d    = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (byte_i == BYTE_START) begin
                        restart_en = 1'b1;
                    end else if (byte_i == BYTE_END) begin
                        end_en  = 1'b1;
                        state_d = ST_IDLE;
                    end else if (byte_i == BYTE_ESC) begin
                        state_d = ST_ESC;
                    end else begin
                        store_en = 1'b1;
                    end
                end
                ST_ESC: begin
                    store_en = 1'b1;
                    state_d  = ST_LOAD;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // A word leaves the buffer when its last lane fills, or at END with a
    // partially filled buffer.
    assign emit_en  = (store_en && (idx_q == LAST_IDX)) || (end_en && (idx_q != '0));
    assign mem_full = (count_q == FULL_COUNT);

    // Lane buffer with the current byte merged in, and its packing into a
    // word in the configured byte order. Unfilled lanes are always zero, so
    // a partial word comes out zero-padded.
    genvar gi;
    generate
        for (gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
            assign lane_wr[gi] = (store_en && (idx_q == IDX_W'(gi))) ? byte_i : lane_q[gi];
            if (BIG_ENDIAN) begin : g_be
                assign word_asm[8*(WORD_BYTES-gi)-1 -: 8] = lane_wr[gi];
            end else begin : g_le
                assign word_asm[8*gi+7 -: 8] = lane_wr[gi];
            end
        end
    endgenerate

    // Next-state for the byte index, buffer, counters, flags and write port.
    always_comb begin
        idx_d      = idx_q;
        lane_d     = lane_wr;
        count_d    = count_q;
        overflow_d = overflow_q;
        partial_d  = partial_q;
        we_d       = 1'b0;
        done_d     = end_en;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if (restart_en) begin
            idx_d      = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            partial_d  = 1'b0;
            for (int k = 0; k < WORD_BYTES; k++) begin
                lane_d[k] = 8'h00;
            end
        end else begin
            if (store_en) begin
                idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
            end
            if (end_en) begin
                idx_d = '0;
                if (idx_q != '0) begin
                    partial_d = 1'b1;
                end
            end
            if (emit_en) begin
                idx_d = '0;
                for (int k = 0; k < WORD_BYTES; k++) begin
                    lane_d[k] = 8'h00;
                end
                if (mem_full) begin
                    overflow_d = 1'b1;
                end else begin
                    we_d    = 1'b1;
                    addr_d  = count_q[ADDR_W-1:0];
                    wdata_d = word_asm;
                    count_d = count_q + (ADDR_W + 1)'(1);
                end
            end
        end
    end

    // State registers with synchronous reset; reset drops any frame in flight.
    always_ff @(posedge clk_i) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            partial_q  <= 1'b0;
            we_q       <= 1'b0;
            done_q     <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            for (int k = 0; k < WORD_BYTES; k++) begin
                lane_q[k] <= 8'h00;
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            partial_q  <= partial_d;
            we_q       <= we_d;
            done_q     <= done_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            for (int k = 0; k < WORD_BYTES; k++) begin
                lane_q[k] <= lane_d[k];
            end
        end
    end

    assign mem_we_o     = we_q;
    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = wdata_q;
    assign busy_o       = (state_q != ST_IDLE);
    assign done_o       = done_q;
    assign word_count_o = count_q;
    assign overflow_o   = overflow_q;
    assign partial_o    = partial_q;

endmodule

// File: tb/tb_instr_stream_loader.sv
// Testbench for instr_stream_loader: one big-endian instance (64 words) and
// one little-endian instance (4 words) share the same byte stream. A frame
// level model per instance predicts every output every cycle; directed
// scenarios additionally pin write logs and flags to literal values.
module tb_instr_stream_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       byte_valid;
    logic [7:0] byte_in;

    logic        we0, busy0, done0, ovf0, part0;
    logic [5:0]  addr0;
    logic [31:0] wd0;
    logic [6:0]  cnt0;
    logic        we1, busy1, done1, ovf1, part1;
    logic [5:0]  addr1;
    logic [31:0] wd1;
    logic [6:0]  cnt1;

    instr_stream_loader #(.WORD_BYTES(4), .DEPTH(64), .ADDR_W(6), .BIG_ENDIAN(1'b1)) u_be (
        .clk_i(clk), .reset(reset), .byte_valid_i(byte_valid), .byte_i(byte_in),
        .mem_we_o(we0), .mem_addr_o(addr0), .mem_wdata_o(wd0), .busy_o(busy0),
        .done_o(done0), .word_count_o(cnt0), .overflow_o(ovf0), .partial_o(part0));

    instr_stream_loader #(.WORD_BYTES(4), .DEPTH(4), .ADDR_W(6), .BIG_ENDIAN(1'b0)) u_le (
        .clk_i(clk), .reset(reset), .byte_valid_i(byte_valid), .byte_i(byte_in),
        .mem_we_o(we1), .mem_addr_o(addr1), .mem_wdata_o(wd1), .busy_o(busy1),
        .done_o(done1), .word_count_o(cnt1), .overflow_o(ovf1), .partial_o(part1));

    int n_cmp  = 0;
    int n_fail = 0;

    // Frame-level model: per instance, the bytes collected for the word in
    // progress, the count of words written, and the flags.
    int         depth_of [2];
    bit         be_of    [2];
    bit         m_frame  [2];
    bit         m_esc    [2];
    logic [7:0] m_bytes  [2][4];
    int         m_n      [2];
    int         m_cnt    [2];
    bit         m_ovf    [2];
    bit         m_part   [2];
    bit         m_we     [2];
    bit         m_done   [2];
    logic [31:0] m_addr  [2];
    logic [31:0] m_wdata [2];

    // Observed DUT writes and done pulses, for the directed checks.
    logic [5:0]  log_a0[$];
    logic [31:0] log_d0[$];
    logic [5:0]  log_a1[$];
    logic [31:0] log_d1[$];
    int done_seen0 = 0;
    int done_seen1 = 0;

    logic [7:0] stim[$];

    task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic logic [31:0] model_pack(input int m);
        logic [31:0] w;
        w = 32'h0;
        for (int k = 0; k < m_n[m]; k++) begin
            if (be_of[m]) w = w | (32'(m_bytes[m][k]) << (8 * (3 - k)));
            else          w = w | (32'(m_bytes[m][k]) << (8 * k));
        end
        return w;
    endfunction

    task automatic model_emit(input int m);
        if (m_cnt[m] == depth_of[m]) begin
            m_ovf[m] = 1'b1;
        end else begin
            m_we[m]    = 1'b1;
            m_addr[m]  = 32'(m_cnt[m]);
            m_wdata[m] = model_pack(m);
            m_cnt[m]++;
        end
        m_n[m] = 0;
    endtask

    task automatic model_push(input int m, input logic [7:0] b);
        m_bytes[m][m_n[m]] = b;
        m_n[m]++;
        if (m_n[m] == 4) model_emit(m);
    endtask

    task automatic model_start(input int m);
        m_frame[m] = 1'b1;
        m_esc[m]   = 1'b0;
        m_n[m]     = 0;
        m_cnt[m]   = 0;
        m_ovf[m]   = 1'b0;
        m_part[m]  = 1'b0;
    endtask

    task automatic model_step(input int m, input logic r, input logic v, input logic [7:0] b);
        m_we[m]   = 1'b0;
        m_done[m] = 1'b0;
        if (r) begin
            m_frame[m] = 1'b0;
            m_esc[m]   = 1'b0;
            m_n[m]     = 0;
            m_cnt[m]   = 0;
            m_ovf[m]   = 1'b0;
            m_part[m]  = 1'b0;
            m_addr[m]  = 32'h0;
            m_wdata[m] = 32'h0;
        end else if (v) begin
            if (!m_frame[m]) begin
                if (b == 8'hFE) model_start(m);
            end else if (m_esc[m]) begin
                m_esc[m] = 1'b0;
                model_push(m, b);
            end else if (b == 8'hFE) begin
                model_start(m);
            end else if (b == 8'hFF) begin
                m_frame[m] = 1'b0;
                m_done[m]  = 1'b1;
                if (m_n[m] > 0) begin
                    m_part[m] = 1'b1;
                    model_emit(m);
                end
            end else if (b == 8'hFD) begin
                m_esc[m] = 1'b1;
            end else begin
                model_push(m, b);
            end
        end
    endtask

    task automatic compare_inst(input int m, input logic we, input logic [5:0] addr,
                                input logic [31:0] wd, input logic busy, input logic done,
                                input logic [6:0] cnt, input logic ovf, input logic part);
        string t;
        t = (m == 0) ? "be" : "le";
        chk({t, " mem_we"},     32'(we),   32'(m_we[m]));
        chk({t, " mem_addr"},   32'(addr), m_addr[m]);
        chk({t, " mem_wdata"},  wd,        m_wdata[m]);
        chk({t, " busy"},       32'(busy), 32'(m_frame[m]));
        chk({t, " done"},       32'(done), 32'(m_done[m]));
        chk({t, " word_count"}, 32'(cnt),  32'(m_cnt[m]));
        chk({t, " overflow"},   32'(ovf),  32'(m_ovf[m]));
        chk({t, " partial"},    32'(part), 32'(m_part[m]));
    endtask

    // Per-cycle checker: sample the inputs at the edge, advance the models,
    // then compare both instances just after the edge.
    initial begin
        logic r, v;
        logic [7:0] b;
        depth_of[0] = 64; be_of[0] = 1'b1;
        depth_of[1] = 4;  be_of[1] = 1'b0;
        forever begin
            @(posedge clk);
            r = reset; v = byte_valid; b = byte_in;
            #1;
            model_step(0, r, v, b);
            model_step(1, r, v, b);
            compare_inst(0, we0, addr0, wd0, busy0, done0, cnt0, ovf0, part0);
            compare_inst(1, we1, addr1, wd1, busy1, done1, cnt1, ovf1, part1);
            if (we0 === 1'b1) begin log_a0.push_back(addr0); log_d0.push_back(wd0); end
            if (we1 === 1'b1) begin log_a1.push_back(addr1); log_d1.push_back(wd1); end
            if (done0 === 1'b1) done_seen0++;
            if (done1 === 1'b1) done_seen1++;
        end
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        byte_valid = 1'b1;
        byte_in    = b;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            byte_valid = 1'b0;
        end
    endtask

    task automatic play();
        foreach (stim[i]) send(stim[i]);
        idle(1);
    endtask

    task automatic clear_logs();
        log_a0.delete(); log_d0.delete();
        log_a1.delete(); log_d1.delete();
        done_seen0 = 0;
        done_seen1 = 0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset      = 1'b1;
        byte_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        byte_valid = 1'b0;
        byte_in    = 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset state.
        chk("reset we",    32'(we0),   32'h0);
        chk("reset addr",  32'(addr0), 32'h0);
        chk("reset wdata", wd0,        32'h0);
        chk("reset busy",  32'(busy0), 32'h0);
        chk("reset count", 32'(cnt0),  32'h0);
        chk("reset flags", {30'h0, ovf0, part0}, 32'h0);

        // Basic big-endian load.
        clear_logs();
        stim = '{8'hFE, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'hFF};
        play(); idle(3);
        chk("basic nwrites", 32'(log_a0.size()), 32'd2);
        if (log_a0.size() >= 2) begin
            chk("basic addr0", 32'(log_a0[0]), 32'd0);
            chk("basic data0", log_d0[0], 32'h00112233);
            chk("basic addr1", 32'(log_a0[1]), 32'd1);
            chk("basic data1", log_d0[1], 32'h44556677);
        end
        chk("basic done pulses", 32'(done_seen0), 32'd1);
        chk("basic count",       32'(cnt0), 32'd2);
        chk("basic partial",     32'(part0), 32'd0);
        chk("basic overflow",    32'(ovf0), 32'd0);

        // Escapes, little-endian instance.
        clear_logs();
        stim = '{8'hFE, 8'hFD, 8'hFF, 8'hFD, 8'hFE, 8'hFD, 8'hFD, 8'h01, 8'hFF};
        play(); idle(3);
        chk("esc nwrites", 32'(log_d1.size()), 32'd1);
        if (log_d1.size() >= 1) chk("esc data0", log_d1[0], 32'h01FDFEFF);
        chk("esc count", 32'(cnt1), 32'd1);

        // Partial word.
        clear_logs();
        stim = '{8'hFE, 8'hAA, 8'hBB, 8'hFF};
        play(); idle(3);
        chk("partial nwrites", 32'(log_d0.size()), 32'd1);
        if (log_d0.size() >= 1) chk("partial data0", log_d0[0], 32'hAABB0000);
        chk("partial flag", 32'(part0), 32'd1);

        // Restart discards the pending byte and clears flags.
        clear_logs();
        stim = '{8'hFE, 8'hAA, 8'hFE, 8'h12, 8'h34, 8'h56, 8'h78, 8'hFF};
        play(); idle(3);
        chk("restart nwrites", 32'(log_d0.size()), 32'd1);
        if (log_d0.size() >= 1) begin
            chk("restart addr0", 32'(log_a0[0]), 32'd0);
            chk("restart data0", log_d0[0], 32'h12345678);
        end
        chk("restart flags", {30'h0, ovf0, part0}, 32'h0);
        chk("restart count", 32'(cnt0), 32'd1);

        // Overflow on the 4-word instance.
        clear_logs();
        stim = '{8'hFE};
        for (int w = 0; w < 5; w++)
            for (int k = 0; k < 4; k++) stim.push_back(8'((w << 4) | k));
        stim.push_back(8'hFF);
        play(); idle(3);
        chk("ovf nwrites", 32'(log_a1.size()), 32'd4);
        for (int i = 0; i < 4 && i < log_a1.size(); i++)
            chk($sformatf("ovf addr%0d", i), 32'(log_a1[i]), 32'(i));
        chk("ovf flag",  32'(ovf1), 32'd1);
        chk("ovf count", 32'(cnt1), 32'd4);

        // Garbage while idle, then a gapped word.
        clear_logs();
        stim = '{8'h11, 8'h22, 8'hFF};
        play(); idle(2);
        chk("idle garbage nwrites", 32'(log_d0.size() + log_d1.size()), 32'd0);
        send(8'hFE); idle(1);
        send(8'hA1); idle(1);
        send(8'hB2); idle(1);
        send(8'hC3); idle(1);
        send(8'hD4);
        @(posedge clk); #2;
        chk("gap we after 4th",  32'(we0), 32'd1);
        chk("gap data",          wd0, 32'hA1B2C3D4);
        chk("gap addr",          32'(addr0), 32'd0);
        idle(1);
        send(8'hFF); idle(3);
        chk("gap nwrites", 32'(log_d0.size()), 32'd1);

        // Reset in the middle of a frame.
        clear_logs();
        stim = '{8'hFE, 8'h01, 8'h02, 8'h03};
        foreach (stim[i]) send(stim[i]);
        pulse_reset();
        send(8'h04); idle(4);
        chk("rst nwrites", 32'(log_d0.size() + log_d1.size()), 32'd0);
        chk("rst done",    32'(done_seen0 + done_seen1), 32'd0);
        chk("rst outputs", {we0, busy0, done0, ovf0, part0, cnt0, addr0}, 32'h0);
        chk("rst wdata",   wd0, 32'h0);

        // Randomized traffic; the per-cycle checker does the comparing.
        for (int c = 0; c < 4000; c++) begin
            int r;
            @(negedge clk);
            reset      = ($urandom_range(0, 399) == 0);
            byte_valid = ($urandom_range(0, 3) != 0);
            r = int'($urandom_range(0, 31));
            case (r)
                0:       byte_in = 8'hFE;
                1:       byte_in = 8'hFF;
                2:       byte_in = 8'hFD;
                default: byte_in = 8'($urandom_range(0, 255));
            endcase
        end
        @(negedge clk);
        reset      = 1'b0;
        byte_valid = 1'b0;
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
